// File: rtl/memory_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_hs
// Description : Memory stage between execute and writeback. Issues data-memory
//               accesses over a req/gnt/rvalid handshake of variable latency,
//               steers sub-word store lanes and extends sub-word loads, flags
//               misaligned/illegal accesses and bus errors, stalls upstream
//               while an access is outstanding and parks a finished result in
//               a hold buffer while downstream is stalled.
// Ports       : clk_i/rst_i (async active-low); execute-side op inputs
//               (v_i, ld_v_i, st_v_i, funct3_i, addr_i, result_i, st_data_i,
//               rd_i, rd_w_v_i); pipeline control (stall_v_i, flush_v_i,
//               stall_o); dmem request/response; registered writeback
//               outputs (v_o, rd_o, rd_w_v_o, result_o, exc_o).
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_hs #(
    parameter int width_p      = 32,
    parameter int addr_width_p = 32,
    parameter int rd_width_p   = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      v_i,
    input  logic                      ld_v_i,
    input  logic                      st_v_i,
    input  logic [2:0]                funct3_i,
    input  logic [addr_width_p-1:0]   addr_i,
    input  logic [width_p-1:0]        result_i,
    input  logic [width_p-1:0]        st_data_i,
    input  logic [rd_width_p-1:0]     rd_i,
    input  logic                      rd_w_v_i,
    input  logic                      stall_v_i,
    input  logic                      flush_v_i,
    output logic                      stall_o,
    output logic                      dmem_req_v_o,
    output logic                      dmem_we_o,
    output logic [addr_width_p-1:0]   dmem_addr_o,
    output logic [width_p/8-1:0]      dmem_be_o,
    output logic [width_p-1:0]        dmem_data_o,
    input  logic                      dmem_gnt_i,
    input  logic                      dmem_rvalid_i,
    input  logic                      dmem_err_i,
    input  logic [width_p-1:0]        dmem_data_i,
    output logic                      v_o,
    output logic [rd_width_p-1:0]     rd_o,
    output logic                      rd_w_v_o,
    output logic [width_p-1:0]        result_o,
    output logic [1:0]                exc_o
);
    localparam int         c_NBYTES   = width_p / 8;
    localparam int         c_OFF_W    = $clog2(c_NBYTES);
    localparam logic       c_WIDE     = (width_p == 64);
    localparam logic [1:0] c_EXC_NONE = 2'd0;
    localparam logic [1:0] c_EXC_MIS  = 2'd1;
    localparam logic [1:0] c_EXC_BUS  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    kill_q, kill_d;
    logic                    is_ld_q, is_ld_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [c_OFF_W-1:0]      off_q, off_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [c_NBYTES-1:0]     be_q, be_d;
    logic [width_p-1:0]      wdata_q, wdata_d;
    logic [rd_width_p-1:0]   rd_q, rd_d;
    logic                    rd_w_v_q, rd_w_v_d;
    logic [width_p-1:0]      hold_result_q, hold_result_d;
    logic                    hold_rd_w_v_q, hold_rd_w_v_d;
    logic [1:0]              hold_exc_q, hold_exc_d;
    logic                    out_v_q, out_v_d;
    logic [rd_width_p-1:0]   out_rd_q, out_rd_d;
    logic                    out_rd_w_v_q, out_rd_w_v_d;
    logic [width_p-1:0]      out_result_q, out_result_d;
    logic [1:0]              out_exc_q, out_exc_d;

    // ---------------- request-side decode of the presented op ----------------
    logic [1:0]          w_size;
    logic [c_OFF_W-1:0]  w_off;
    logic                w_f3_legal;
    logic                w_aligned;
    logic                w_misalign;
    logic [c_NBYTES-1:0] w_mask;
    logic [c_NBYTES-1:0] w_be;
    logic [width_p-1:0]  w_st_steer;

    assign w_size = funct3_i[1:0];
    assign w_off  = addr_i[c_OFF_W-1:0];

    // Unsigned loads have no store counterpart; 64-bit accesses only exist on a 64-bit bus.
    always_comb begin
        case (funct3_i)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = ld_v_i;
            3'b011:                 w_f3_legal = c_WIDE;
            3'b110:                 w_f3_legal = c_WIDE & ld_v_i;
            default:                w_f3_legal = 1'b0;
        endcase
    end

    // (1 << size) - 1 wraps to 3'b111 for doubles, which is the wanted mask.
    assign w_aligned  = ((addr_i[2:0] & ((3'd1 << w_size) - 3'd1)) == 3'd0);
    assign w_misalign = ~w_f3_legal | ~w_aligned;

    always_comb begin
        case (w_size)
            2'd0: begin
                w_mask     = c_NBYTES'(1);
                w_st_steer = {c_NBYTES{st_data_i[7:0]}};
            end
            2'd1: begin
                w_mask     = c_NBYTES'(3);
                w_st_steer = {(c_NBYTES/2){st_data_i[15:0]}};
            end
            2'd2: begin
                w_mask     = c_NBYTES'(15);
                w_st_steer = {(c_NBYTES/4){st_data_i[31:0]}};
            end
            default: begin
                w_mask     = '1;
                w_st_steer = st_data_i;
            end
        endcase
    end

    assign w_be = w_mask << w_off;

    // ---------------- response-side formatting ----------------
    logic [width_p-1:0] w_ld_shift;
    logic [width_p-1:0] w_ld_ext;
    logic [width_p-1:0] w_rsp_result;
    logic               w_rsp_rd_w_v;
    logic [1:0]         w_rsp_exc;

    assign w_ld_shift = dmem_data_i >> {off_q, 3'b000};

    // funct3[2] set means zero-extend.
    always_comb begin
        case (funct3_q[1:0])
            2'd0: begin
                if (funct3_q[2]) w_ld_ext = width_p'(w_ld_shift[7:0]);
                else             w_ld_ext = width_p'($signed(w_ld_shift[7:0]));
            end
            2'd1: begin
                if (funct3_q[2]) w_ld_ext = width_p'(w_ld_shift[15:0]);
                else             w_ld_ext = width_p'($signed(w_ld_shift[15:0]));
            end
            2'd2: begin
                if (funct3_q[2]) w_ld_ext = width_p'(w_ld_shift[31:0]);
                else             w_ld_ext = width_p'($signed(w_ld_shift[31:0]));
            end
            default: w_ld_ext = w_ld_shift;
        endcase
    end

    always_comb begin
        w_rsp_result = '0;
        w_rsp_rd_w_v = 1'b0;
        w_rsp_exc    = c_EXC_NONE;
        if (dmem_err_i) begin
            w_rsp_exc = c_EXC_BUS;
        end else if (is_ld_q) begin
            w_rsp_result = w_ld_ext;
            w_rsp_rd_w_v = rd_w_v_q;
        end
    end

    // ---------------- next-state logic ----------------
    logic                  w_wb_v;
    logic [rd_width_p-1:0] w_wb_rd;
    logic                  w_wb_rd_w_v;
    logic [width_p-1:0]    w_wb_result;
    logic [1:0]            w_wb_exc;

    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        is_ld_d       = is_ld_q;
        funct3_d      = funct3_q;
        off_d         = off_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        rd_d          = rd_q;
        rd_w_v_d      = rd_w_v_q;
        hold_result_d = hold_result_q;
        hold_rd_w_v_d = hold_rd_w_v_q;
        hold_exc_d    = hold_exc_q;
        // Candidate for the output register; all-zero is a bubble.
        w_wb_v        = 1'b0;
        w_wb_rd       = '0;
        w_wb_rd_w_v   = 1'b0;
        w_wb_result   = '0;
        w_wb_exc      = c_EXC_NONE;

        case (state_q)
            S_IDLE: begin
                if (v_i && !stall_o && !flush_v_i) begin
                    if (!ld_v_i && !st_v_i) begin
                        w_wb_v      = 1'b1;
                        w_wb_rd     = rd_i;
                        w_wb_rd_w_v = rd_w_v_i;
                        w_wb_result = result_i;
                    end else if (w_misalign) begin
                        w_wb_v   = 1'b1;
                        w_wb_rd  = rd_i;
                        w_wb_exc = c_EXC_MIS;
                    end else begin
                        is_ld_d  = ld_v_i;
                        funct3_d = funct3_i;
                        off_d    = w_off;
                        addr_d   = {addr_i[addr_width_p-1:c_OFF_W], {c_OFF_W{1'b0}}};
                        be_d     = w_be;
                        wdata_d  = w_st_steer;
                        rd_d     = rd_i;
                        rd_w_v_d = rd_w_v_i;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // The request stays up until granted, even when flushed.
                if (flush_v_i)  kill_d  = 1'b1;
                if (dmem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dmem_rvalid_i) begin
                    if (kill_q || flush_v_i) begin
                        state_d = S_IDLE;
                    end else if (!stall_v_i) begin
                        w_wb_v      = 1'b1;
                        w_wb_rd     = rd_q;
                        w_wb_rd_w_v = w_rsp_rd_w_v;
                        w_wb_result = w_rsp_result;
                        w_wb_exc    = w_rsp_exc;
                        state_d     = S_IDLE;
                    end else begin
                        hold_result_d = w_rsp_result;
                        hold_rd_w_v_d = w_rsp_rd_w_v;
                        hold_exc_d    = w_rsp_exc;
                        state_d       = S_HOLD;
                    end
                end else if (flush_v_i) begin
                    kill_d = 1'b1;
                end
            end
            default: begin // S_HOLD
                if (flush_v_i) begin
                    state_d = S_IDLE;
                end else if (!stall_v_i) begin
                    w_wb_v      = 1'b1;
                    w_wb_rd     = rd_q;
                    w_wb_rd_w_v = hold_rd_w_v_q;
                    w_wb_result = hold_result_q;
                    w_wb_exc    = hold_exc_q;
                    state_d     = S_IDLE;
                end
            end
        endcase

        if (state_d == S_IDLE) kill_d = 1'b0;

        // Flush beats a downstream stall for the output register.
        out_v_d      = out_v_q;
        out_rd_d     = out_rd_q;
        out_rd_w_v_d = out_rd_w_v_q;
        out_result_d = out_result_q;
        out_exc_d    = out_exc_q;
        if (flush_v_i) begin
            out_v_d      = 1'b0;
            out_rd_d     = '0;
            out_rd_w_v_d = 1'b0;
            out_result_d = '0;
            out_exc_d    = c_EXC_NONE;
        end else if (!stall_v_i) begin
            out_v_d      = w_wb_v;
            out_rd_d     = w_wb_rd;
            out_rd_w_v_d = w_wb_rd_w_v;
            out_result_d = w_wb_result;
            out_exc_d    = w_wb_exc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= S_IDLE;
            kill_q        <= 1'b0;
            is_ld_q       <= 1'b0;
            funct3_q      <= '0;
            off_q         <= '0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            rd_q          <= '0;
            rd_w_v_q      <= 1'b0;
            hold_result_q <= '0;
            hold_rd_w_v_q <= 1'b0;
            hold_exc_q    <= c_EXC_NONE;
            out_v_q       <= 1'b0;
            out_rd_q      <= '0;
            out_rd_w_v_q  <= 1'b0;
            out_result_q  <= '0;
            out_exc_q     <= c_EXC_NONE;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            is_ld_q       <= is_ld_d;
            funct3_q      <= funct3_d;
            off_q         <= off_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            rd_q          <= rd_d;
            rd_w_v_q      <= rd_w_v_d;
            hold_result_q <= hold_result_d;
            hold_rd_w_v_q <= hold_rd_w_v_d;
            hold_exc_q    <= hold_exc_d;
            out_v_q       <= out_v_d;
            out_rd_q      <= out_rd_d;
            out_rd_w_v_q  <= out_rd_w_v_d;
            out_result_q  <= out_result_d;
            out_exc_q     <= out_exc_d;
        end
    end

    assign stall_o      = (state_q != S_IDLE) | stall_v_i;
    assign dmem_req_v_o = (state_q == S_REQ);
    assign dmem_we_o    = ~is_ld_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_data_o  = wdata_q;
    assign v_o          = out_v_q;
    assign rd_o         = out_rd_q;
    assign rd_w_v_o     = out_rd_w_v_q;
    assign result_o     = out_result_q;
    assign exc_o        = out_exc_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage_hs
// Description : Directed self-checking bench for memory_stage_hs (32-bit
//               bus). Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage_hs;
    localparam int c_W  = 32;
    localparam int c_AW = 32;
    localparam int c_RW = 5;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            v_i, ld_v_i, st_v_i;
    logic [2:0]      funct3_i;
    logic [c_AW-1:0] addr_i;
    logic [c_W-1:0]  result_i, st_data_i;
    logic [c_RW-1:0] rd_i;
    logic            rd_w_v_i, stall_v_i, flush_v_i;
    logic            stall_o, dmem_req_v_o, dmem_we_o;
    logic [c_AW-1:0] dmem_addr_o;
    logic [c_W/8-1:0] dmem_be_o;
    logic [c_W-1:0]  dmem_data_o;
    logic            dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
    logic [c_W-1:0]  dmem_data_i;
    logic            v_o;
    logic [c_RW-1:0] rd_o;
    logic            rd_w_v_o;
    logic [c_W-1:0]  result_o;
    logic [1:0]      exc_o;

    int n_tests = 0;
    int n_fail  = 0;

    memory_stage_hs #(
        .width_p      (c_W),
        .addr_width_p (c_AW),
        .rd_width_p   (c_RW)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .v_i           (v_i),
        .ld_v_i        (ld_v_i),
        .st_v_i        (st_v_i),
        .funct3_i      (funct3_i),
        .addr_i        (addr_i),
        .result_i      (result_i),
        .st_data_i     (st_data_i),
        .rd_i          (rd_i),
        .rd_w_v_i      (rd_w_v_i),
        .stall_v_i     (stall_v_i),
        .flush_v_i     (flush_v_i),
        .stall_o       (stall_o),
        .dmem_req_v_o  (dmem_req_v_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_data_o   (dmem_data_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_err_i    (dmem_err_i),
        .dmem_data_i   (dmem_data_i),
        .v_o           (v_o),
        .rd_o          (rd_o),
        .rd_w_v_o      (rd_w_v_o),
        .result_o      (result_o),
        .exc_o         (exc_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        v_i = 0; ld_v_i = 0; st_v_i = 0; funct3_i = 3'b000; addr_i = '0;
        result_i = '0; st_data_i = '0; rd_i = '0; rd_w_v_i = 0;
        stall_v_i = 0; flush_v_i = 0;
        dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_err_i = 0; dmem_data_i = '0;
    endtask

    task automatic nonmem_op(input logic [31:0] res, input logic [4:0] rd);
        v_i = 1; ld_v_i = 0; st_v_i = 0; result_i = res; rd_i = rd; rd_w_v_i = 1;
        tick();
        v_i = 0;
    endtask

    // Present a memory op, drive gnt after gnt_dly idle cycles, return rvalid
    // with stall_v_i held high for stall_cyc cycles, then check writeback.
    task automatic mem_op(input string tag, input logic ld, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] rdata, input logic err,
                          input int gnt_dly, input int stall_cyc,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                          input logic exp_wv, input logic [1:0] exp_exc);
        v_i = 1; ld_v_i = ld; st_v_i = !ld; funct3_i = f3; addr_i = addr;
        st_data_i = sd; rd_i = 5'd9; rd_w_v_i = 1;
        #1 check({tag, "_accept_stall"}, stall_o, 0);
        tick();
        // Scramble the inputs so only captured values can appear on the bus.
        v_i = 0; ld_v_i = 0; st_v_i = 0; funct3_i = 3'b111;
        addr_i = 32'hFFFF_FFFF; st_data_i = 32'h0;
        for (int c = 0; c <= gnt_dly; c++) begin
            dmem_gnt_i = (c == gnt_dly);
            #1;
            check({tag, "_req_v"}, dmem_req_v_o, 1);
            check({tag, "_addr"}, dmem_addr_o, exp_addr);
            check({tag, "_be"}, dmem_be_o, exp_be);
            check({tag, "_we"}, dmem_we_o, !ld);
            if (!ld) check({tag, "_wdata"}, dmem_data_o, exp_wdata);
            check({tag, "_req_stall"}, stall_o, 1);
            tick();
        end
        dmem_gnt_i = 0;
        dmem_rvalid_i = 1; dmem_data_i = rdata; dmem_err_i = err;
        stall_v_i = (stall_cyc > 0);
        #1;
        check({tag, "_wait_noreq"}, dmem_req_v_o, 0);
        check({tag, "_wait_stall"}, stall_o, 1);
        tick();
        dmem_rvalid_i = 0; dmem_err_i = 0;
        if (stall_cyc > 0) begin
            for (int c = 1; c < stall_cyc; c++) begin
                check({tag, "_held_v"}, v_o, 0);
                tick();
            end
            stall_v_i = 0;
            #1;
            // stall_v_i is low here, so stall_o can only come from HOLD.
            check({tag, "_hold_stall"}, stall_o, 1);
            check({tag, "_hold_v"}, v_o, 0);
            tick();
        end
        check({tag, "_v"}, v_o, 1);
        check({tag, "_rd"}, rd_o, 9);
        check({tag, "_wv"}, rd_w_v_o, exp_wv);
        check({tag, "_exc"}, exc_o, exp_exc);
        if (exp_exc == 2'd0) check({tag, "_result"}, result_o, exp_res);
        check({tag, "_done_stall"}, stall_o, 0);
    endtask

    task automatic mis_op(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        v_i = 1; ld_v_i = 1; st_v_i = 0; funct3_i = f3; addr_i = addr; rd_i = 5'd4; rd_w_v_i = 1;
        tick();
        v_i = 0; ld_v_i = 0;
        check({tag, "_noreq"}, dmem_req_v_o, 0);
        check({tag, "_idle"}, stall_o, 0);
        check({tag, "_v"}, v_o, 1);
        check({tag, "_exc"}, exc_o, 1);
        check({tag, "_wv"}, rd_w_v_o, 0);
        check({tag, "_rd"}, rd_o, 4);
    endtask

    initial begin
        idle_inputs();
        rst_i = 0;
        repeat (3) tick();
        check("rst_v", v_o, 0);
        check("rst_result", result_o, 0);
        check("rst_rd", rd_o, 0);
        check("rst_wv", rd_w_v_o, 0);
        check("rst_exc", exc_o, 0);
        check("rst_req", dmem_req_v_o, 0);
        check("rst_stall", stall_o, 0);
        rst_i = 1;
        tick();

        // Non-memory op, latency 1.
        nonmem_op(32'h1234, 5'd5);
        check("alu_v", v_o, 1);
        check("alu_result", result_o, 32'h1234);
        check("alu_rd", rd_o, 5);
        check("alu_wv", rd_w_v_o, 1);
        check("alu_exc", exc_o, 0);
        tick();
        check("alu_bubble", v_o, 0);

        // Loads and stores with the fastest handshake.
        mem_op("lb",  1, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 0,
               32'h1000, 4'b1000, 32'h0, 32'hFFFFFF80, 1, 2'd0);
        mem_op("lbu", 1, 3'b100, 32'h1003, 32'h0, 32'h80AABBCC, 0, 0, 0,
               32'h1000, 4'b1000, 32'h0, 32'h00000080, 1, 2'd0);
        mem_op("lh",  1, 3'b001, 32'h1002, 32'h0, 32'h80AABBCC, 0, 0, 0,
               32'h1000, 4'b1100, 32'h0, 32'hFFFF80AA, 1, 2'd0);
        mem_op("lhu", 1, 3'b101, 32'h1000, 32'h0, 32'h80AABBCC, 0, 0, 0,
               32'h1000, 4'b0011, 32'h0, 32'h0000BBCC, 1, 2'd0);
        mem_op("sh",  0, 3'b001, 32'h2002, 32'h0000BEEF, 32'h0, 0, 0, 0,
               32'h2000, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, 2'd0);
        mem_op("sb",  0, 3'b000, 32'h7001, 32'h123456A5, 32'h0, 0, 0, 0,
               32'h7000, 4'b0010, 32'hA5A5A5A5, 32'h0, 0, 2'd0);
        // Delayed grant plus downstream stall across the response.
        mem_op("lw_slow", 1, 3'b010, 32'h4008, 32'h0, 32'hDEADBEEF, 0, 3, 2,
               32'h4008, 4'b1111, 32'h0, 32'hDEADBEEF, 1, 2'd0);
        // Bus error.
        mem_op("lw_err", 1, 3'b010, 32'h6004, 32'h0, 32'h11111111, 1, 1, 0,
               32'h6004, 4'b1111, 32'h0, 32'h0, 0, 2'd2);

        // Misaligned and illegal encodings.
        mis_op("lw_mis", 3'b010, 32'h3001);
        mis_op("lh_mis", 3'b001, 32'h3003);
        mis_op("ld_on32", 3'b011, 32'h3000);
        mis_op("f3_111", 3'b111, 32'h3000);
        tick();

        // Flush wins over stall for the output register.
        nonmem_op(32'h55, 5'd2);
        check("fs_pre_v", v_o, 1);
        stall_v_i = 1; flush_v_i = 1;
        tick();
        flush_v_i = 0;
        check("fs_v", v_o, 0);
        check("fs_result", result_o, 0);
        v_i = 1; result_i = 32'h77; rd_i = 5'd1;
        #1 check("fs_stall_o", stall_o, 1);
        tick();
        v_i = 0; stall_v_i = 0;
        check("fs_not_taken", v_o, 0);
        tick();
        check("fs_still_empty", v_o, 0);

        // Flush in WAIT, then an erroring response is discarded.
        v_i = 1; ld_v_i = 1; funct3_i = 3'b010; addr_i = 32'h5000; rd_i = 5'd9;
        tick();
        v_i = 0; ld_v_i = 0; dmem_gnt_i = 1;
        tick();
        dmem_gnt_i = 0; flush_v_i = 1;
        tick();
        flush_v_i = 0; dmem_rvalid_i = 1; dmem_err_i = 1; dmem_data_i = 32'hCAFE0000;
        #1 check("fw_still_busy", stall_o, 1);
        tick();
        dmem_rvalid_i = 0; dmem_err_i = 0;
        check("fw_v", v_o, 0);
        check("fw_exc", exc_o, 0);
        check("fw_idle", stall_o, 0);
        nonmem_op(32'hABCD, 5'd3);
        check("fw_next_v", v_o, 1);
        check("fw_next_result", result_o, 32'hABCD);

        // Flush arriving together with rvalid.
        v_i = 1; ld_v_i = 1; funct3_i = 3'b010; addr_i = 32'h5004; rd_i = 5'd9;
        tick();
        v_i = 0; ld_v_i = 0; dmem_gnt_i = 1;
        tick();
        dmem_gnt_i = 0; dmem_rvalid_i = 1; flush_v_i = 1; dmem_data_i = 32'h12345678;
        tick();
        dmem_rvalid_i = 0; flush_v_i = 0;
        check("fr_v", v_o, 0);
        check("fr_idle", stall_o, 0);
        tick();
        check("fr_v2", v_o, 0);

        // Reset mid-access abandons the request immediately.
        v_i = 1; ld_v_i = 1; funct3_i = 3'b010; addr_i = 32'h8000;
        tick();
        v_i = 0; ld_v_i = 0;
        check("mr_req", dmem_req_v_o, 1);
        rst_i = 0;
        #1;
        check("mr_req_drop", dmem_req_v_o, 0);
        check("mr_stall", stall_o, 0);
        tick();
        rst_i = 1;
        tick();
        check("mr_v", v_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
